ternary_dmem_copier: RTL and testbench

TERNARY_DMEM_COPIER -- requirements
Module: ternary_dmem_copier

---
 rtl/ternary_pkg.sv | 39 +++
 rtl/ternary_addr_inc.sv | 32 +++
 rtl/ternary_dmem_copier.sv | 135 +++++++++++++
 tb/tb_ternary_dmem_copier.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared balanced-ternary types plus the copier state encoding and an
// address-to-integer helper used when validating copy requests.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO    = 2'b00;
    localparam trit_t T_POS_ONE = 2'b01;
    localparam trit_t T_NEG_ONE = 2'b10;

    // Widest address the helper converts; 3^19 still fits a signed int.
    localparam int MAX_ADDR_TRITS = 19;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } copier_state_e;

    // Horner evaluation from the most significant trit; 2'b11 reads as zero.
    function automatic int trit_addr_to_int(input logic [2*MAX_ADDR_TRITS-1:0] bits,
                                            input int n_trits);
        int acc;
        acc = 0;
        for (int i = MAX_ADDR_TRITS - 1; i >= 0; i--) begin
            if (i < n_trits) begin
                acc = acc * 3;
                if (bits[2*i +: 2] == T_POS_ONE) begin
                    acc = acc + 1;
                end else if (bits[2*i +: 2] == T_NEG_ONE) begin
                    acc = acc - 1;
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/ternary_addr_inc.sv
// Combinational balanced-ternary +1 over an ADDR_WIDTH-trit address.
module ternary_addr_inc
    import ternary_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  trit_t [ADDR_WIDTH-1:0] addr_i,
    output trit_t [ADDR_WIDTH-1:0] addr_o
);

    logic carry;

    // +1 on a +1 trit yields -1 with a carry; any other trit absorbs the carry.
    always_comb begin
        carry  = 1'b1;
        addr_o = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (!carry) begin
                addr_o[i] = addr_i[i];
            end else if (addr_i[i] == T_POS_ONE) begin
                addr_o[i] = T_NEG_ONE;
            end else if (addr_i[i] == T_NEG_ONE) begin
                addr_o[i] = T_ZERO;
                carry     = 1'b0;
            end else begin
                addr_o[i] = T_POS_ONE;
                carry     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ternary_dmem_copier.sv
// Word-by-word data-memory copier: one READ and one WRITE cycle per word,
// ascending order, with request validation, abort and a FINISH pulse.
module ternary_dmem_copier
    import ternary_pkg::*;
#(
    parameter int TRIT_WIDTH = 27,
    parameter int ADDR_WIDTH = 9,
    parameter int DMEM_DEPTH = 729
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  trit_t [ADDR_WIDTH-1:0]  src_addr,
    input  trit_t [ADDR_WIDTH-1:0]  dst_addr,
    input  logic  [9:0]             length,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output trit_t [ADDR_WIDTH-1:0]  dmem_addr,
    output trit_t [TRIT_WIDTH-1:0]  dmem_wdata,
    input  trit_t [TRIT_WIDTH-1:0]  dmem_rdata,
    output logic                    dmem_we,
    output logic                    dmem_re
);

    copier_state_e             state_q, state_d;
    trit_t [ADDR_WIDTH-1:0]    src_q, src_d, src_next;
    trit_t [ADDR_WIDTH-1:0]    dst_q, dst_d, dst_next;
    trit_t [TRIT_WIDTH-1:0]    buf_q, buf_d;
    logic  [9:0]               cnt_q, cnt_d;
    logic                      error_q, error_d;

    logic [2*MAX_ADDR_TRITS-1:0] src_pad, dst_pad;
    int                          src_int, dst_int, len_int;
    logic                        req_ok;

    ternary_addr_inc #(.ADDR_WIDTH(ADDR_WIDTH)) u_src_inc (.addr_i(src_q), .addr_o(src_next));
    ternary_addr_inc #(.ADDR_WIDTH(ADDR_WIDTH)) u_dst_inc (.addr_i(dst_q), .addr_o(dst_next));

    // Request check works on signed integers so negative addresses are rejected.
    always_comb begin
        src_pad                       = '0;
        dst_pad                       = '0;
        src_pad[2*ADDR_WIDTH-1:0]     = src_addr;
        dst_pad[2*ADDR_WIDTH-1:0]     = dst_addr;
        src_int                       = trit_addr_to_int(src_pad, ADDR_WIDTH);
        dst_int                       = trit_addr_to_int(dst_pad, ADDR_WIDTH);
        len_int                       = {22'd0, length};
        req_ok = (src_int >= 0) && (dst_int >= 0) &&
                 (src_int + len_int <= DMEM_DEPTH) && (dst_int + len_int <= DMEM_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!req_ok) begin
                        error_d = 1'b1;
                    end else if (length == 10'd0) begin
                        state_d = ST_FINISH;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        cnt_d   = length;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    buf_d   = dmem_rdata;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Abort wins over the last word completing.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    src_d   = src_next;
                    dst_d   = dst_next;
                    cnt_d   = cnt_q - 10'd1;
                    state_d = (cnt_q == 10'd1) ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    // Outputs decode straight from state so reset takes effect without a clock.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
        error      = error_q;
        dmem_re    = (state_q == ST_READ);
        dmem_we    = (state_q == ST_WRITE) && !abort;
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (state_q == ST_READ) begin
            dmem_addr = src_q;
        end else if (state_q == ST_WRITE) begin
            dmem_addr  = dst_q;
            dmem_wdata = buf_q;
        end
    end

endmodule

// File: tb/tb_ternary_dmem_copier.sv
// Bench for ternary_dmem_copier: ternary data memory, integer reference model
// of each copy, directed cases followed by randomized copies.
module tb_ternary_dmem_copier;
    import ternary_pkg::*;

    localparam int TW    = 27;
    localparam int AW    = 9;
    localparam int DEPTH = 729;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    trit_t [AW-1:0]    src_addr, dst_addr;
    logic  [9:0]       length;
    logic              busy, done, error, dmem_we, dmem_re;
    trit_t [AW-1:0]    dmem_addr;
    trit_t [TW-1:0]    dmem_wdata, dmem_rdata;

    logic [2*TW-1:0]   mem [DEPTH];
    longint            ref_mem [DEPTH];
    logic              load_en = 1'b0;
    int                load_idx = 0;
    logic [2*TW-1:0]   load_data = '0;
    int                we_total = 0;
    int                addr_idx;

    int n_tests = 0;
    int n_fail  = 0;

    ternary_dmem_copier #(.TRIT_WIDTH(TW), .ADDR_WIDTH(AW), .DMEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .error(error),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .dmem_re(dmem_re)
    );

    always #5 clk = ~clk;

    function automatic longint t2i(input logic [2*TW-1:0] v, input int n);
        longint acc;
        acc = 0;
        for (int i = n - 1; i >= 0; i--) begin
            acc = acc * 3;
            if (v[2*i +: 2] == 2'b01) acc = acc + 1;
            else if (v[2*i +: 2] == 2'b10) acc = acc - 1;
        end
        return acc;
    endfunction

    function automatic logic [2*TW-1:0] i2t(input longint v);
        logic [2*TW-1:0] r;
        longint x, m;
        r = '0;
        x = v;
        for (int i = 0; i < TW; i++) begin
            m = x % 3;
            if (m < 0) m = m + 3;
            if (m == 1) begin
                r[2*i +: 2] = 2'b01;
                x = (x - 1) / 3;
            end else if (m == 2) begin
                r[2*i +: 2] = 2'b10;
                x = (x + 1) / 3;
            end else begin
                x = x / 3;
            end
        end
        return r;
    endfunction

    function automatic logic [2*AW-1:0] to_addr(input int v);
        logic [2*TW-1:0] full;
        full = i2t(longint'(v));
        return full[2*AW-1:0];
    endfunction

    function automatic int addr_val(input logic [2*AW-1:0] a);
        logic [2*TW-1:0] full;
        full = '0;
        full[2*AW-1:0] = a;
        return int'(t2i(full, AW));
    endfunction

    // Memory: combinational read, write on the clock edge when dmem_we is high.
    always_comb begin
        addr_idx   = addr_val(dmem_addr);
        dmem_rdata = (addr_idx >= 0 && addr_idx < DEPTH) ? mem[addr_idx] : '0;
    end

    always @(posedge clk) begin
        if (dmem_we) begin
            if (addr_idx >= 0 && addr_idx < DEPTH) mem[addr_idx] <= dmem_wdata;
            we_total <= we_total + 1;
        end else if (load_en) begin
            mem[load_idx] <= load_data;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_word(input int idx, input longint val);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = i2t(val);
        ref_mem[idx] = val;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        int diffs;
        diffs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (t2i(mem[i], TW) != ref_mem[i]) diffs++;
        end
        check({tag, "_mem_diffs"}, diffs, 0);
    endtask

    task automatic do_copy(input string tag, input int s, input int d, input int l,
                           input int abort_c, input int restart_c, input int rst_c);
        int  ok, cut, k, last, ncyc, done_cyc, done_n, err_n, bad, we0, j;
        logic exp_busy;
        ok  = (s >= 0 && d >= 0 && s + l <= DEPTH && d + l <= DEPTH) ? 1 : 0;
        cut = (abort_c > 0) ? abort_c : rst_c;
        // Word j is written at the end of cycle 2j+2; anything cut earlier never lands.
        k = 0;
        if (ok != 0) begin
            for (int w = 0; w < l; w++) if (cut == 0 || 2 * (w + 1) < cut) k++;
        end
        for (int w = 0; w < k; w++) ref_mem[d + w] = ref_mem[s + w];
        last = (cut > 0) ? cut : 2 * l + 1;

        we0 = we_total;
        @(negedge clk);
        src_addr = to_addr(s);
        dst_addr = to_addr(d);
        length   = 10'(l);
        start    = 1'b1;
        ncyc = 2 * l + 6;
        done_cyc = -1;
        done_n = 0;
        err_n = 0;
        bad = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            abort = (c == abort_c);
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, busy, 0);
                check({tag, "_rst_done"}, done, 0);
                check({tag, "_rst_error"}, error, 0);
                check({tag, "_rst_we"}, dmem_we, 0);
                check({tag, "_rst_re"}, dmem_re, 0);
                check({tag, "_rst_addr"}, dmem_addr, 0);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            #1;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (error) err_n++;
            if (error !== ((c == 1) && (ok == 0))) bad++;
            exp_busy = (ok != 0) && (c <= last);
            if (busy !== exp_busy) bad++;
            if (!exp_busy) begin
                if (dmem_we !== 1'b0 || dmem_re !== 1'b0 || dmem_addr !== '0 || dmem_wdata !== '0) bad++;
            end else if (c <= 2 * l) begin
                j = (c - 1) / 2;
                if (c % 2 == 1) begin
                    if (dmem_re !== 1'b1 || dmem_we !== 1'b0 || addr_val(dmem_addr) != s + j) bad++;
                end else begin
                    if (dmem_re !== 1'b0 || dmem_we !== (c != abort_c) ||
                        addr_val(dmem_addr) != d + j) bad++;
                    if (c != abort_c && t2i(dmem_wdata, TW) != ref_mem[d + j]) bad++;
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (rst_c == 0) begin
            check({tag, "_cycle_bad"}, bad, 0);
            check({tag, "_done_count"}, done_n, (ok != 0 && cut == 0) ? 1 : 0);
            check({tag, "_done_cycle"}, done_cyc, (ok != 0 && cut == 0) ? 2 * l + 1 : -1);
            check({tag, "_error_count"}, err_n, (ok != 0) ? 0 : 1);
        end
        check({tag, "_we_count"}, we_total - we0, k);
        check_mem(tag);
    endtask

    initial begin
        int s, d, l, a, r;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        rst_n    = 1'b0;
        for (int i = 0; i < DEPTH; i++) load_word(i, longint'($urandom_range(0, 200000)) - 100000);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_we", dmem_we, 0);
        check("reset_re", dmem_re, 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_word(10, 5);
        load_word(11, -7);
        load_word(12, 13);
        do_copy("basic", 10, 20, 3, 0, 0, 0);
        check("basic_w20", t2i(mem[20], TW), 5);
        check("basic_w21", t2i(mem[21], TW), -7);
        check("basic_w22", t2i(mem[22], TW), 13);
        do_copy("len0", 0, 0, 0, 0, 0, 0);
        do_copy("oob", 700, 0, 40, 0, 0, 0);
        do_copy("restart", 30, 40, 4, 0, 2, 0);
        do_copy("abort", 50, 60, 3, 4, 0, 0);
        do_copy("midrst", 70, 80, 5, 0, 0, 4);
        do_copy("after_rst", 0, 100, 2, 0, 0, 0);
        do_copy("overlap_up", 200, 202, 6, 0, 0, 0);
        do_copy("overlap_dn", 310, 308, 5, 0, 0, 0);
        do_copy("edge_src_ok", 700, 0, 29, 0, 0, 0);
        do_copy("edge_src_bad", 700, 0, 30, 0, 0, 0);
        do_copy("edge_dst_ok", 5, 719, 10, 0, 0, 0);
        do_copy("neg_src", -3, 10, 2, 0, 0, 0);
        do_copy("abort_read", 400, 420, 4, 3, 0, 0);
        do_copy("abort_last", 430, 440, 2, 4, 0, 0);

        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 780)) - 20;
            d = int'($urandom_range(0, 780)) - 20;
            l = int'($urandom_range(0, 25));
            a = 0;
            r = 0;
            if (l > 0 && s >= 0 && d >= 0 && s + l <= DEPTH && d + l <= DEPTH) begin
                if ($urandom_range(0, 3) == 0) a = int'($urandom_range(1, 2 * l));
                else if ($urandom_range(0, 3) == 0) r = int'($urandom_range(1, 2 * l + 1));
            end
            do_copy("rand", s, d, l, a, r, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
